// File: rtl/cpu_types_pkg.sv
// Shared CPU pipeline types: hazard-controller state, latch control bundle and NOP encoding.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DWAIT = 2'd1,
        HALT  = 2'd2
    } hz_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } hz_ctrl_t;

    // Bundle order: pc, ifid, idex, exmem, memwb enables, then the four flushes
    localparam hz_ctrl_t CTRL_IDLE   = hz_ctrl_t'(9'b00000_0000);
    localparam hz_ctrl_t CTRL_ALL_EN = hz_ctrl_t'(9'b11111_0000);
    localparam hz_ctrl_t CTRL_DWAIT  = hz_ctrl_t'(9'b00000_0001);
    localparam hz_ctrl_t CTRL_BRANCH = hz_ctrl_t'(9'b11111_1110);
    localparam hz_ctrl_t CTRL_BUBBLE = hz_ctrl_t'(9'b00111_0100);
    localparam hz_ctrl_t CTRL_JUMP   = hz_ctrl_t'(9'b11111_1000);

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Load-use comparator: flags an ID instruction that needs the result of a load still in EX.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memRd,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             hazard
);

    logic dest_live_s;
    logic rs_match_s;
    logic rt_match_s;

    // $zero is never a real dependency, so a load targeting it cannot stall
    assign dest_live_s = ex_memRd & (ex_rt != {REG_W{1'b0}});
    assign rs_match_s  = (ex_rt == id_rs);
    assign rt_match_s  = id_uses_rt & (ex_rt == id_rt);
    assign hazard      = dest_live_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing: PC/latch enables and flushes for load-use, memory waits,
// branches, jumps and halt, plus a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int REG_W       = 5,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   ihit,
    input  logic                   dhit,
    input  logic                   mem_dreq,
    input  logic [REG_W-1:0]       id_rs,
    input  logic [REG_W-1:0]       id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_memRd,
    input  logic [REG_W-1:0]       ex_rt,
    input  logic                   mem_br_taken,
    input  logic                   id_jump,
    input  logic                   wb_halt,
    output logic                   pc_en,
    output logic                   ifid_en,
    output logic                   idex_en,
    output logic                   exmem_en,
    output logic                   memwb_en,
    output logic                   ifid_flush,
    output logic                   idex_flush,
    output logic                   exmem_flush,
    output logic                   memwb_flush,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] CNT_MAX = {STALL_CNT_W{1'b1}};

    hz_state_t              state_r;
    logic [STALL_CNT_W-1:0] stall_cnt_r;
    hz_ctrl_t               ctrl_s;
    logic                   load_use_s;
    logic                   dwait_s;
    logic                   count_s;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .ex_memRd   (ex_memRd),
        .ex_rt      (ex_rt),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_uses_rt (id_uses_rt),
        .hazard     (load_use_s)
    );

    assign dwait_s = mem_dreq & ~dhit;

    // Output priority mux; the release cycle of DWAIT falls through to the branch check
    always_comb begin
        ctrl_s = CTRL_IDLE;
        if (!nRST) begin
            ctrl_s = CTRL_IDLE;
        end else begin
            case (state_r)
                RUN, DWAIT: begin
                    if (dwait_s) begin
                        ctrl_s = CTRL_DWAIT;
                    end else if (mem_br_taken) begin
                        ctrl_s = CTRL_BRANCH;
                    end else if (load_use_s) begin
                        ctrl_s = CTRL_BUBBLE;
                    end else if (id_jump) begin
                        ctrl_s = CTRL_JUMP;
                    end else if (!ihit) begin
                        ctrl_s = CTRL_BUBBLE;
                    end else begin
                        ctrl_s = CTRL_ALL_EN;
                    end
                end
                HALT:    ctrl_s = CTRL_IDLE;
                default: ctrl_s = CTRL_IDLE;
            endcase
        end
    end

    assign count_s = ~ctrl_s.pc_en & (state_r != HALT) & (stall_cnt_r != CNT_MAX);

    // State register and saturating stall counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_r     <= RUN;
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else begin
            if (wb_halt) begin
                state_r <= HALT;
            end else begin
                case (state_r)
                    RUN:     state_r <= dwait_s ? DWAIT : RUN;
                    DWAIT:   state_r <= dhit ? RUN : DWAIT;
                    HALT:    state_r <= HALT;
                    default: state_r <= RUN;
                endcase
            end
            if (count_s) begin
                stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
        end
    end

    assign pc_en       = ctrl_s.pc_en;
    assign ifid_en     = ctrl_s.ifid_en;
    assign idex_en     = ctrl_s.idex_en;
    assign exmem_en    = ctrl_s.exmem_en;
    assign memwb_en    = ctrl_s.memwb_en;
    assign ifid_flush  = ctrl_s.ifid_flush;
    assign idex_flush  = ctrl_s.idex_flush;
    assign exmem_flush = ctrl_s.exmem_flush;
    assign memwb_flush = ctrl_s.memwb_flush;
    assign halted      = (state_r == HALT);
    assign stall_cnt   = stall_cnt_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle sequences.
module tb_pipeline_hazard_ctrl;

    localparam logic [8:0] E_IDLE = 9'b00000_0000;
    localparam logic [8:0] E_ALL  = 9'b11111_0000;
    localparam logic [8:0] E_DW   = 9'b00000_0001;
    localparam logic [8:0] E_BR   = 9'b11111_1110;
    localparam logic [8:0] E_LU   = 9'b00111_0100;
    localparam logic [8:0] E_JMP  = 9'b11111_1000;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, mem_dreq, id_uses_rt, ex_memRd, mem_br_taken, id_jump, wb_halt;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush, memwb_flush, halted;
    logic [15:0] stall_cnt;
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_memwb_flush, s_halted;
    logic [1:0]  s_stall_cnt;
    logic [8:0]  ctrl_bus;

    typedef struct {
        logic       ihit, dhit, mem_dreq;
        logic [4:0] id_rs, id_rt;
        logic       id_uses_rt, ex_memRd;
        logic [4:0] ex_rt;
        logic       br, jmp;
        logic [8:0] exp;
    } vec_t;

    typedef struct {
        logic [8:0]  ctrl;
        logic        halted;
        logic [15:0] cnt;
    } exp_t;

    vec_t  vecs[14];
    exp_t  sb_q[$];
    int    checks = 0;
    int    errors = 0;
    int    model_cnt = 0;
    int    sat_model = 0;

    always #5 CLK = ~CLK;

    assign ctrl_bus = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                       ifid_flush, idex_flush, exmem_flush, memwb_flush};

    pipeline_hazard_ctrl #(.REG_W(5), .STALL_CNT_W(16)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_memRd(ex_memRd),
        .ex_rt(ex_rt), .mem_br_taken(mem_br_taken), .id_jump(id_jump), .wb_halt(wb_halt),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.REG_W(5), .STALL_CNT_W(2)) sat_dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dreq(mem_dreq),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_memRd(ex_memRd),
        .ex_rt(ex_rt), .mem_br_taken(mem_br_taken), .id_jump(id_jump), .wb_halt(wb_halt),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en), .exmem_en(s_exmem_en),
        .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush),
        .exmem_flush(s_exmem_flush), .memwb_flush(s_memwb_flush), .halted(s_halted),
        .stall_cnt(s_stall_cnt)
    );

    function automatic vec_t mk(input logic ih, input logic dh, input logic md,
                                input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                                input logic mrd, input logic [4:0] ert, input logic br,
                                input logic jmp, input logic [8:0] exp);
        vec_t v;
        v.ihit = ih; v.dhit = dh; v.mem_dreq = md; v.id_rs = rs; v.id_rt = rt;
        v.id_uses_rt = urt; v.ex_memRd = mrd; v.ex_rt = ert; v.br = br; v.jmp = jmp;
        v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string tag, input string what, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, what, act, req);
        end
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.scoreboard actual=empty required=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk(tag, "ctrl", {23'd0, ctrl_bus}, {23'd0, e.ctrl});
            chk(tag, "halted", {31'd0, halted}, {31'd0, e.halted});
            chk(tag, "stall_cnt", {16'd0, stall_cnt}, {16'd0, e.cnt});
        end
    endtask

    // Push expectation, sample on the falling edge, advance the model past the rising edge
    task automatic step(input logic [8:0] exp_ctrl, input logic exp_halt, input string tag);
        exp_t e;
        e.ctrl = exp_ctrl;
        e.halted = exp_halt;
        e.cnt = 16'(model_cnt);
        sb_q.push_back(e);
        @(negedge CLK);
        check_out(tag);
        if (!exp_ctrl[8] && !exp_halt) begin
            if (model_cnt < 65535) model_cnt++;
            if (sat_model < 3) sat_model++;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs;
        ihit = 1'b1; dhit = 1'b0; mem_dreq = 1'b0; id_rs = 5'd0; id_rt = 5'd0;
        id_uses_rt = 1'b0; ex_memRd = 1'b0; ex_rt = 5'd0; mem_br_taken = 1'b0;
        id_jump = 1'b0; wb_halt = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        exp_t e;
        nRST = 1'b0;
        idle_inputs();
        @(negedge CLK);
        e.ctrl = E_IDLE; e.halted = 1'b0; e.cnt = 16'd0;
        sb_q.push_back(e);
        check_out(tag);
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        model_cnt = 0;
        sat_model = 0;
    endtask

    initial begin
        exp_t e;
        vecs[0]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU);
        vecs[1]  = mk(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, E_ALL);
        vecs[2]  = mk(1'b1, 1'b0, 1'b0, 5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, E_LU);
        vecs[3]  = mk(1'b1, 1'b0, 1'b0, 5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, E_ALL);
        vecs[4]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b0, 5'd8, 1'b0, 1'b0, E_ALL);
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_JMP);
        vecs[6]  = mk(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_LU);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, E_LU);
        vecs[8]  = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, E_BR);
        vecs[9]  = mk(1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, E_BR);
        vecs[10] = mk(1'b1, 1'b0, 1'b0, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b1, E_LU);
        vecs[11] = mk(1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, E_JMP);
        vecs[12] = mk(1'b1, 1'b0, 1'b1, 5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, E_DW);
        vecs[13] = mk(1'b1, 1'b1, 1'b1, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, E_ALL);

        do_reset("reset0");
        for (int i = 0; i < 14; i++) begin
            ihit = vecs[i].ihit; dhit = vecs[i].dhit; mem_dreq = vecs[i].mem_dreq;
            id_rs = vecs[i].id_rs; id_rt = vecs[i].id_rt; id_uses_rt = vecs[i].id_uses_rt;
            ex_memRd = vecs[i].ex_memRd; ex_rt = vecs[i].ex_rt;
            mem_br_taken = vecs[i].br; id_jump = vecs[i].jmp;
            step(vecs[i].exp, 1'b0, $sformatf("vec%0d", i));
        end

        // Three-cycle data wait, then release with all latches enabled
        do_reset("reset_dw");
        mem_dreq = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) step(E_DW, 1'b0, $sformatf("dwait%0d", i));
        dhit = 1'b1;
        step(E_ALL, 1'b0, "dwait_release");
        chk("dwait_release", "model_cnt", 32'(model_cnt), 32'd3);

        // Branch held across a data wait is applied on the release cycle
        do_reset("reset_brw");
        mem_dreq = 1'b1; dhit = 1'b0; mem_br_taken = 1'b1;
        for (int i = 0; i < 3; i++) step(E_DW, 1'b0, $sformatf("brwait%0d", i));
        dhit = 1'b1;
        step(E_BR, 1'b0, "brwait_release");

        // Halt with a concurrent fetch stall, hold, then mid-cycle reset
        do_reset("reset_halt");
        ihit = 1'b0; wb_halt = 1'b1;
        step(E_LU, 1'b0, "halt_in");
        wb_halt = 1'b0;
        for (int i = 0; i < 10; i++) step(E_IDLE, 1'b1, $sformatf("halted%0d", i));
        #3;
        nRST = 1'b0;
        #1;
        e.ctrl = E_IDLE; e.halted = 1'b0; e.cnt = 16'd0;
        sb_q.push_back(e);
        check_out("halt_rst");
        model_cnt = 0;
        sat_model = 0;
        @(posedge CLK);
        #1;
        nRST = 1'b1; ihit = 1'b1;
        step(E_ALL, 1'b0, "post_rst");

        // Narrow counter saturates instead of wrapping
        do_reset("reset_sat");
        ihit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(E_LU, 1'b0, $sformatf("sat%0d", i));
            chk($sformatf("sat%0d", i), "sat_cnt", {30'd0, s_stall_cnt}, 32'(sat_model));
        end
        chk("sat_final", "sat_cnt", {30'd0, s_stall_cnt}, 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
